// File: rtl/us_pkg.sv
// us_pkg: shared constants and line-state encoding for the receive-line acquisition blocks.
package us_pkg;
    localparam int US_DW = 12;
    typedef enum logic [1:0] {IDLE, WAIT, ACQ} line_state_t;
endpackage

// File: rtl/us_line_decim_if.sv
// us_line_decim_if: control, sample-in and decimated-out signals of one receive-line decimator.
interface us_line_decim_if
    import us_pkg::*;
#(
    parameter int DW      = US_DW,
    parameter int DEPTH_W = 12,
    parameter int NS_W    = 10
);
    logic               iTrig;
    logic [DEPTH_W-1:0] iStartDly;
    logic [NS_W-1:0]    iNumOut;
    logic [DW-1:0]      iData;
    logic [DW-1:0]      oData;
    logic               oValid;
    logic [NS_W-1:0]    oIndex;
    logic               oBusy;
    logic               oDone;
    logic               oTrigLost;
    modport master (
        output iTrig, iStartDly, iNumOut, iData,
        input  oData, oValid, oIndex, oBusy, oDone, oTrigLost
    );
    modport slave (
        input  iTrig, iStartDly, iNumOut, iData,
        output oData, oValid, oIndex, oBusy, oDone, oTrigLost
    );
endinterface

// File: rtl/us_boxcar_acc.sv
// us_boxcar_acc: load/add accumulator over a 2^DEC_LOG2 sample group with floor-divided mean.
module us_boxcar_acc
    import us_pkg::*;
#(
    parameter int DW       = US_DW,
    parameter int DEC_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [DEC_LOG2-1:0]   phase_i,
    input  logic signed [DW-1:0]  data_i,
    output logic signed [DW-1:0]  avg_o,
    output logic                  last_o
);
    localparam int AW = DW + DEC_LOG2;
    logic signed [AW-1:0] acc_q, acc_d, sum;
    // First sample of a group overwrites the accumulator, so no separate clear cycle is needed.
    always_comb begin
        sum    = (phase_i == '0) ? AW'(data_i) : acc_q + AW'(data_i);
        acc_d  = en_i ? sum : acc_q;
        avg_o  = DW'(sum >>> DEC_LOG2);
        last_o = (phase_i == '1);
    end
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
endmodule

// File: rtl/us_line_decim.sv
// us_line_decim: trigger-gated acquisition window with boxcar decimation for one receive line.
module us_line_decim
    import us_pkg::*;
#(
    parameter int DW       = US_DW,
    parameter int DEC_LOG2 = 2,
    parameter int DEPTH_W  = 12,
    parameter int NS_W     = 10
) (
    input logic            clk,
    input logic            rst,
    us_line_decim_if.slave bus
);
    line_state_t         state_q, state_d;
    logic [DEPTH_W-1:0]  dcnt_q, dcnt_d;
    logic [NS_W-1:0]     n_q, n_d, idx_q, idx_d, index_q, index_d;
    logic [DEC_LOG2-1:0] ph_q, ph_d;
    logic [DW-1:0]       data_q, data_d;
    logic                valid_q, valid_d, done_q, done_d, lost_q, lost_d, busy_q, busy_d;
    logic signed [DW-1:0] avg;
    logic                last, start, fire, fin;

    assign start = (state_q == IDLE) && bus.iTrig;
    assign fire  = (state_q == ACQ) && last;
    assign fin   = fire && (idx_q == n_q - 1'b1);

    us_boxcar_acc #(.DW(DW), .DEC_LOG2(DEC_LOG2)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ACQ),
        .phase_i(ph_q),
        .data_i (bus.iData),
        .avg_o  (avg),
        .last_o (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (start ? ((bus.iNumOut == '0) ? IDLE :
                                                (bus.iStartDly == '0) ? ACQ : WAIT) : IDLE)
                : (state_q == WAIT) ? ((dcnt_q == DEPTH_W'(1)) ? ACQ : WAIT)
                : (fin ? IDLE : ACQ);
    end

    // The depth counter is loaded with S and leaves WAIT on its last skipped cycle.
    always_comb begin
        dcnt_d  = start ? bus.iStartDly : (state_q == WAIT) ? dcnt_q - 1'b1 : dcnt_q;
        n_d     = start ? bus.iNumOut : n_q;
        ph_d    = start ? '0 : (state_q == ACQ) ? ph_q + 1'b1 : ph_q;
        idx_d   = start ? '0 : fire ? idx_q + 1'b1 : idx_q;
        data_d  = fire ? avg : data_q;
        index_d = fire ? idx_q : index_q;
        valid_d = fire;
        done_d  = (start && bus.iNumOut == '0) || fin;
        lost_d  = bus.iTrig && (state_q != IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q  <= '0;
            n_q     <= '0;
            ph_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            n_q     <= n_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.oData     = data_q;
    assign bus.oValid    = valid_q;
    assign bus.oIndex    = index_q;
    assign bus.oBusy     = busy_q;
    assign bus.oDone     = done_q;
    assign bus.oTrigLost = lost_q;
endmodule
